// File: rtl/up_count_checker.sv
// Monitor for a WIDTH-bit up counter: checks every sampled step for a hold,
// +1, rollover or upstream reset, counts rollovers, raises a sticky alarm
// after ALARM_WRAPS wraps and latches the first illegal value.
//
// state | meaning
// ------+---------------------------------------------------------------
// SYNC  | first edge after reset/clr, only captures prev, nothing checked
// TRACK | every sampled count is classified against prev
// ERR   | illegal step seen; wrap tracking frozen until clr or reset
module up_count_checker #(
    parameter int WIDTH       = 4,
    parameter int WRAP_W      = 8,
    parameter int ALARM_WRAPS = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WIDTH-1:0]  i_count,
    input  logic              i_clr,
    output logic              o_wrap_pulse,
    output logic [WRAP_W-1:0] o_wrap_cnt,
    output logic              o_alarm,
    output logic              o_step_err,
    output logic [WIDTH-1:0]  o_err_value,
    output logic [1:0]        o_state
);

    localparam logic [1:0] SYNC  = 2'b00;
    localparam logic [1:0] TRACK = 2'b01;
    localparam logic [1:0] ERR   = 2'b10;

    localparam logic [WIDTH-1:0]  MAX_CNT   = '1;
    localparam logic [WIDTH-1:0]  ZERO_CNT  = '0;
    localparam logic [WRAP_W-1:0] WRAP_SAT  = '1;
    localparam logic [WRAP_W-1:0] ALARM_CNT = WRAP_W'(ALARM_WRAPS);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WIDTH-1:0]  r_prev;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_wrap_pulse;
    logic              r_alarm;
    logic              r_step_err;
    logic [WIDTH-1:0]  r_err_value;

    logic [WIDTH-1:0]  w_inc;
    logic              w_prev_max;
    logic              w_hold;
    logic              w_step_up;
    logic              w_rollover;
    logic              w_up_reset;
    logic              w_illegal;
    logic              w_wrap_ev;
    logic              w_err_ev;
    logic [WRAP_W-1:0] w_wrap_cnt_nxt;

    // Classify the sampled count against the previous sample.
    always_comb begin
        w_inc      = r_prev + WIDTH'(1);
        w_prev_max = (r_prev == MAX_CNT);
        w_hold     = (i_count == r_prev);
        w_step_up  = (i_count == w_inc) && !w_prev_max;
        w_rollover = w_prev_max && (i_count == ZERO_CNT);
        // Upstream synchronous reset to 0 from a mid-range value is legal and
        // is not a wrap; prev==0 with count==0 is already covered by hold.
        w_up_reset = (i_count == ZERO_CNT) && !w_prev_max && (r_prev != ZERO_CNT);
        w_illegal  = !(w_hold || w_step_up || w_rollover || w_up_reset);
        // clr wins over anything sampled on the same edge.
        w_wrap_ev  = (r_state == TRACK) && w_rollover && !i_clr;
        w_err_ev   = (r_state == TRACK) && w_illegal && !i_clr;
    end

    // Next wrap count, saturating at all ones.
    always_comb begin
        w_wrap_cnt_nxt = r_wrap_cnt;
        if (r_wrap_cnt != WRAP_SAT) begin
            w_wrap_cnt_nxt = r_wrap_cnt + WRAP_W'(1);
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = SYNC;
        end else begin
            case (r_state)
                SYNC:    w_state_nxt = TRACK;
                TRACK:   w_state_nxt = w_illegal ? ERR : TRACK;
                ERR:     w_state_nxt = ERR;
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Previous-sample register, loaded every edge except under clr.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else if (!i_clr) begin
            r_prev <= i_count;
        end
    end

    // Rollover pulse and saturating wrap counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrap_pulse <= 1'b0;
            r_wrap_cnt   <= '0;
        end else if (i_clr) begin
            r_wrap_pulse <= 1'b0;
            r_wrap_cnt   <= '0;
        end else begin
            r_wrap_pulse <= w_wrap_ev;
            if (w_wrap_ev) begin
                r_wrap_cnt <= w_wrap_cnt_nxt;
            end
        end
    end

    // Sticky alarm, set on the wrap that brings the count to ALARM_WRAPS.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alarm <= 1'b0;
        end else if (i_clr) begin
            r_alarm <= 1'b0;
        end else if (w_wrap_ev && (w_wrap_cnt_nxt == ALARM_CNT)) begin
            r_alarm <= 1'b1;
        end
    end

    // Sticky step error; only the first illegal value is kept since ERR
    // never re-enters TRACK without a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_err  <= 1'b0;
            r_err_value <= '0;
        end else if (i_clr) begin
            r_step_err  <= 1'b0;
            r_err_value <= '0;
        end else if (w_err_ev) begin
            r_step_err  <= 1'b1;
            r_err_value <= i_count;
        end
    end

    assign o_wrap_pulse = r_wrap_pulse;
    assign o_wrap_cnt   = r_wrap_cnt;
    assign o_alarm      = r_alarm;
    assign o_step_err   = r_step_err;
    assign o_err_value  = r_err_value;
    assign o_state      = r_state;

endmodule

// File: tb/tb_up_count_checker.sv
// Directed bench for up_count_checker: default instance for the main
// behaviour, a narrow instance (WRAP_W=2, ALARM_WRAPS=3) for async reset
// with alarm set and for wrap-count saturation.
module tb_up_count_checker;

    logic       clk;
    logic       rstn0, clr0, rstn1, clr1;
    logic [3:0] c0, c1;

    logic       p0, a0, e0, p1, a1, e1;
    logic [7:0] n0;
    logic [1:0] n1;
    logic [3:0] v0, v1;
    logic [1:0] s0, s1;

    int total = 0;
    int bad   = 0;
    int npulse;

    up_count_checker dut0 (
        .i_clk(clk), .i_rst_n(rstn0), .i_count(c0), .i_clr(clr0),
        .o_wrap_pulse(p0), .o_wrap_cnt(n0), .o_alarm(a0),
        .o_step_err(e0), .o_err_value(v0), .o_state(s0)
    );

    up_count_checker #(.WIDTH(4), .WRAP_W(2), .ALARM_WRAPS(3)) dut1 (
        .i_clk(clk), .i_rst_n(rstn1), .i_count(c1), .i_clr(clr1),
        .o_wrap_pulse(p1), .o_wrap_cnt(n1), .o_alarm(a1),
        .o_step_err(e1), .o_err_value(v1), .o_state(s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic [3:0] v);
        c0 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [3:0] v);
        c1 = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn0 = 1'b0; clr0 = 1'b0; c0 = 4'd0;
        rstn1 = 1'b0; clr1 = 1'b0; c1 = 4'd0;
        #1;
        chk("rst_state", s0, 0);
        chk("rst_pulse", p0, 0);
        chk("rst_cnt", n0, 0);
        chk("rst_alarm", a0, 0);
        chk("rst_err", e0, 0);
        chk("rst_errv", v0, 0);
        #11;
        rstn0 = 1'b1;

        // 1: first edge is SYNC, then count 0..15,0 gives one wrap
        drive0(4'd0);
        chk("t1_track", s0, 1);
        npulse = 0;
        for (int i = 1; i <= 15; i++) begin
            drive0(4'(i));
            npulse += int'(p0);
        end
        chk("t1_no_early_pulse", npulse, 0);
        drive0(4'd0);
        chk("t1_wrap_pulse", p0, 1);
        chk("t1_wrap_cnt", n0, 1);
        chk("t1_step_err", e0, 0);
        drive0(4'd1);
        chk("t1_pulse_drop", p0, 0);

        // 2: wraps up to 10 raise the alarm, two more keep it
        for (int k = 2; k <= 12; k++) begin
            for (int i = (k == 2) ? 2 : 1; i <= 15; i++) drive0(4'(i));
            if (k == 10) chk("t2_alarm_before", a0, 0);
            drive0(4'd0);
            if (k == 9)  chk("t2_alarm_at9", a0, 0);
            if (k == 10) chk("t2_alarm_at10", a0, 1);
            if (k == 10) chk("t2_cnt10", n0, 10);
        end
        chk("t2_cnt12", n0, 12);
        chk("t2_alarm_kept", a0, 1);

        // 3: 4,5,7 is illegal; ERR freezes wraps and keeps first value
        for (int i = 1; i <= 5; i++) drive0(4'(i));
        chk("t3_no_err_yet", e0, 0);
        drive0(4'd7);
        chk("t3_step_err", e0, 1);
        chk("t3_err_value", v0, 7);
        chk("t3_state_err", s0, 2);
        for (int i = 8; i <= 15; i++) drive0(4'(i));
        drive0(4'd0);
        chk("t3_no_wrap_pulse", p0, 0);
        chk("t3_cnt_frozen", n0, 12);
        drive0(4'd2);
        drive0(4'd9);
        chk("t3_errv_kept", v0, 7);
        chk("t3_still_err", s0, 2);

        // leave ERR via clr
        clr0 = 1'b1;
        drive0(4'd0);
        clr0 = 1'b0;
        chk("clr_state", s0, 0);
        chk("clr_err", e0, 0);
        chk("clr_errv", v0, 0);
        chk("clr_cnt", n0, 0);
        chk("clr_alarm", a0, 0);

        // 4: upstream mid-count reset 8,9,0,0,1 is legal
        npulse = 0;
        drive0(4'd8);
        drive0(4'd9);
        drive0(4'd0);
        npulse += int'(p0);
        drive0(4'd0);
        npulse += int'(p0);
        drive0(4'd1);
        npulse += int'(p0);
        chk("t4_no_err", e0, 0);
        chk("t4_no_pulse", npulse, 0);
        chk("t4_track", s0, 1);

        // 6a: clr on the same edge as a 15->0 sample discards the wrap
        for (int i = 2; i <= 15; i++) drive0(4'(i));
        drive0(4'd0);
        chk("t6_pre_cnt", n0, 1);
        for (int i = 1; i <= 15; i++) drive0(4'(i));
        clr0 = 1'b1;
        drive0(4'd0);
        clr0 = 1'b0;
        chk("t6_clr_pulse", p0, 0);
        chk("t6_clr_cnt", n0, 0);
        chk("t6_clr_state", s0, 0);

        // 5: narrow instance, reach wrap_cnt=3 with alarm, then async reset
        rstn1 = 1'b1;
        drive1(4'd0);
        for (int k = 1; k <= 3; k++) begin
            for (int i = 1; i <= 15; i++) drive1(4'(i));
            drive1(4'd0);
        end
        chk("t5_pre_cnt", n1, 3);
        chk("t5_pre_alarm", a1, 1);
        #2;
        rstn1 = 1'b0;
        #1;
        chk("t5_async_cnt", n1, 0);
        chk("t5_async_alarm", a1, 0);
        chk("t5_async_state", s1, 0);
        chk("t5_async_pulse", p1, 0);
        chk("t5_async_err", e1, 0);
        rstn1 = 1'b1;
        #1;
        chk("t5_sync_state", s1, 0);
        drive1(4'd9);
        chk("t5_track", s1, 1);
        chk("t5_sync_no_err", e1, 0);

        // 6b: WRAP_W=2 saturates at 3 over five wraps
        for (int i = 10; i <= 15; i++) drive1(4'(i));
        drive1(4'd0);
        chk("t6_sat_w1", n1, 1);
        for (int k = 2; k <= 5; k++) begin
            for (int i = 1; i <= 15; i++) drive1(4'(i));
            drive1(4'd0);
            chk("t6_sat_pulse", p1, 1);
        end
        chk("t6_sat_cnt", n1, 3);
        chk("t6_sat_alarm", a1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_count_checker.md
Name: up_count_checker

Overview:
Downstream monitor for the 4-bit synchronous up counter. It samples the counter's count bus every clock and checks that each step is legal: hold, +1, or a return to 0. It detects and counts rollovers (max -> 0) and raises a sticky alarm after a programmable number of wraps. It also latches the first illegal step for debug and gives the bench and system logic a self-checking view of the counter.

Parameters:
WIDTH, 4, width of the monitored count bus.
WRAP_W, 8, width of the wrap counter.
ALARM_WRAPS, 10, wrap_cnt value at which alarm asserts. Legal range 1 .. 2^WRAP_W-1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
count  in  WIDTH  count bus from the upstream up counter, same clock domain.
clr  in  1  synchronous clear of all status and the FSM. Active high.
wrap_pulse  out  1  one-cycle pulse on a detected rollover.
wrap_cnt  out  WRAP_W  number of rollovers since reset or clr. Saturates.
alarm  out  1  sticky; wrap_cnt has reached ALARM_WRAPS.
step_err  out  1  sticky; an illegal step was seen.
err_value  out  WIDTH  the count value sampled at the first illegal step.
state  out  2  FSM state: 00 SYNC, 01 TRACK, 10 ERR.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately):
  - all outputs are 0; state=SYNC; internal prev register is 0.
- Register update:
  - all outputs are registered.
  - the effect of the count sampled at rising edge N is visible right after edge N (latency 1 edge, no combinational paths to outputs).
- prev is loaded with count on every edge, in every state, unless clr=1.
- Definitions: MAX = 2^WIDTH-1. inc = (prev+1) mod 2^WIDTH.
- SYNC:
  - the first edge after reset or clr only captures prev; no checking is done.
  - next state is TRACK.
- TRACK, for each sampled count:
  - count==prev: legal hold. No action.
  - count==inc and prev!=MAX: legal increment.
  - prev==MAX and count==0: rollover.
    - wrap_pulse=1 for exactly this one cycle.
    - wrap_cnt increments, saturating at 2^WRAP_W-1.
  - count==0 and prev!=MAX, prev!=0: legal upstream sync reset. No wrap, no error.
  - any other value: illegal step.
    - step_err=1.
    - err_value=count.
    - next state is ERR.
- ERR:
  - wrap detection and wrap_cnt are frozen; wrap_pulse stays 0.
  - step_err and err_value hold; only the first error is recorded.
  - ERR is left only via clr or rst.
- alarm:
  - set on the edge where wrap_cnt becomes ALARM_WRAPS, i.e. the same edge as the wrap_pulse that causes it.
  - stays set under further wraps and through saturation, until clr or rst.
- wrap_pulse is 0 on every edge without a rollover; it never stays high for two consecutive cycles.
- clr=1 at an edge:
  - wrap_cnt, alarm, step_err, err_value, wrap_pulse all go to 0.
  - state goes to SYNC.
  - clr has priority over any rollover or error sampled on the same edge; that event is discarded.
- Reset mid-operation: asynchronous clear as above. Checking restarts with the SYNC cycle after rst is released.

Test Plan:
1. rst=0 for 12 ns, then release; drive count 0,1,..,15,0 on successive edges. Expect:
   - state goes SYNC -> TRACK.
   - exactly one wrap_pulse, on the edge that samples 0 after 15.
   - wrap_cnt=1, step_err=0.
2. Run 10 full 0..15 cycles. Expect alarm=1 on the 10th wrap edge, with wrap_cnt=10. Run 2 more cycles: alarm stays 1, wrap_cnt=12.
3. Drive the sequence 4,5,7. Expect:
   - step_err=1, err_value=7, state=ERR on the edge that samples 7.
   - a later 15 -> 0 gives no wrap_pulse; wrap_cnt unchanged.
   - a later 2 -> 9 leaves err_value=7.
4. Mid-count upstream reset: 8,9,0,0,1. Expect no step_err and no wrap_pulse; state stays TRACK.
5. Assert rst=0 asynchronously between edges while wrap_cnt=3 and alarm=1. Expect all outputs 0 before the next edge; after release, one SYNC cycle, then TRACK.
6. Assert clr=1 on the same edge as a 15 -> 0 sample. Expect wrap_pulse=0, wrap_cnt=0, state=SYNC. Also override WRAP_W=2: 5 wraps leave wrap_cnt saturated at 3.
